// File: rtl/fetch_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue_if
// Bundles the fetch stage's PC, instruction-memory and decode-side signals.
// master: the fetch stage itself; slave: PC register, I-MEM and decode.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic [PC_W-1:0]   pc_in;
  logic [PC_W-1:0]   pc_next;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [4:0]        imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;

  modport master (
    input  fetch_en, pc_in, redirect, redirect_pc, imem_rdata, out_ready,
    output pc_next, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output fetch_en, pc_in, redirect, redirect_pc, imem_rdata, out_ready,
    input  pc_next, imem_addr, out_valid, out_instr, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch stage: computes next PC, addresses the synchronous I-MEM,
// and buffers PC-tagged instructions in a small FIFO drained by decode.
// A redirect flushes the FIFO and drops any fetch still in flight.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic [PC_W-1:0]   tag_pc_q, tag_pc_d;
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic [CW:0]       credits_used;

  // Issue/push/pop decisions, next PC and next-state values.
  // Credits count both buffered and in-flight entries, so the FIFO can
  // never overflow; a same-cycle pop deliberately frees no credit.
  always_comb begin
    credits_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue        = bus.fetch_en & ~bus.redirect & (credits_used < (CW+1)'(DEPTH));
    push         = inflight_q & ~bus.redirect;
    pop          = (count_q != '0) & bus.out_ready & ~bus.redirect;

    bus.imem_addr = bus.pc_in[6:2];

    if (reset) begin
      bus.pc_next = '0;
    end else if (bus.redirect) begin
      bus.pc_next = {bus.redirect_pc[PC_W-1:2], 2'b00};
    end else if (issue) begin
      bus.pc_next = bus.pc_in + PC_W'(4);
    end else begin
      bus.pc_next = bus.pc_in;
    end

    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = issue;
    tag_pc_d   = issue ? bus.pc_in : tag_pc_q;

    if (bus.redirect) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // FIFO state, storage and in-flight tracking; async clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      tag_pc_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      tag_pc_q   <= tag_pc_d;
      if (push) begin
        instr_mem_q[wptr_q] <= bus.imem_rdata;
        pc_mem_q[wptr_q]    <= tag_pc_q;
      end
    end
  end

  // Head entry comes straight from the storage registers, so it is stable
  // while decode stalls and reads as zero after reset.
  always_comb begin
    bus.out_valid = (count_q != '0);
    bus.out_instr = instr_mem_q[rptr_q];
    bus.out_pc    = pc_mem_q[rptr_q];
  end

endmodule
`default_nettype wire
